tile_rd_addr_gen: RTL and testbench

- Generates on-chip feature-map buffer read addresses for one input tile, as a 3-level nested loop: row, then column, then channel (innermost).
- Sits directly downstream of the loop counters and feeds the buffer read port, through a valid/ready handshake.
- A tile of ROW x COL x CH words is read from a larger map stored row-major, channel-interleaved, with row pitch FM_COL*CH.
- Emits a one-cycle done pulse when the tile has been fully issued.

---
 rtl/tile_rd_addr_gen_pkg.sv | 16 +
 rtl/tile_rd_addr_gen_loop_cnt.sv | 27 ++
 rtl/tile_rd_addr_gen.sv | 125 ++++++++++++
 tb/tb_tile_rd_addr_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tile_rd_addr_gen_pkg.sv
// Shared definitions for the tile read address generator: FSM encoding and
// the row-pitch derivation used to step between feature-map rows.
package tile_rd_addr_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Words between vertically adjacent pixels in the row-major, channel-interleaved map.
    function automatic int unsigned row_pitch(input int unsigned fm_col, input int unsigned ch);
        return fm_col * ch;
    endfunction

endpackage

// File: rtl/tile_rd_addr_gen_loop_cnt.sv
// One level of the tile loop nest: a modulo-MAX counter with a last-value flag
// that the parent chains into the increment of the next outer level.
module tile_rd_addr_gen_loop_cnt #(
    parameter int MAX = 4,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    assign wrap = (cnt == CW'(MAX - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tile_rd_addr_gen.sv
// Issues buffer read addresses for one ROW x COL x CH tile (row, column,
// channel innermost) over a valid/ready handshake, then pulses done.
module tile_rd_addr_gen
    import tile_rd_addr_gen_pkg::*;
#(
    parameter int AW     = 16,
    parameter int ROW    = 4,
    parameter int COL    = 4,
    parameter int CH     = 8,
    parameter int FM_COL = 16,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic          clean,
    output logic [AW-1:0] addr,
    output logic          addr_valid,
    input  logic          addr_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] PITCH   = AW'(row_pitch(FM_COL, CH));
    localparam logic [AW-1:0] CH_STEP = AW'(CH);

    state_t        state;
    logic [AW-1:0] row_base;
    logic [AW-1:0] pix_base;
    logic [CW-1:0] ch_cnt, c_cnt, r_cnt;
    logic          ch_wrap, c_wrap, r_wrap;
    logic          accept;
    logic          cnt_clr;
    logic          unused_cnt;

    assign accept  = (state == ST_RUN) && addr_valid && addr_ready && !clean;
    assign cnt_clr = clean || ((state == ST_IDLE) && start);
    assign busy    = (state == ST_RUN);

    // Loop position is carried by the wrap flags; the raw counts are observation only.
    assign unused_cnt = ^{ch_cnt, c_cnt, r_cnt};

    tile_rd_addr_gen_loop_cnt #(.MAX(CH), .CW(CW)) u_ch_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (accept),
        .cnt (ch_cnt),
        .wrap(ch_wrap)
    );

    tile_rd_addr_gen_loop_cnt #(.MAX(COL), .CW(CW)) u_c_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (accept && ch_wrap),
        .cnt (c_cnt),
        .wrap(c_wrap)
    );

    tile_rd_addr_gen_loop_cnt #(.MAX(ROW), .CW(CW)) u_r_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (accept && ch_wrap && c_wrap),
        .cnt (r_cnt),
        .wrap(r_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr       <= '0;
            addr_valid <= 1'b0;
            done       <= 1'b0;
            row_base   <= '0;
            pix_base   <= '0;
        end else if (clean) begin
            state      <= ST_IDLE;
            addr_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        row_base   <= base;
                        pix_base   <= base;
                        addr       <= base;
                        addr_valid <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Each level restarts from the base of the level above it.
                    if (accept) begin
                        if (!ch_wrap) begin
                            addr <= addr + AW'(1);
                        end else if (!c_wrap) begin
                            pix_base <= pix_base + CH_STEP;
                            addr     <= pix_base + CH_STEP;
                        end else if (!r_wrap) begin
                            row_base <= row_base + PITCH;
                            pix_base <= row_base + PITCH;
                            addr     <= row_base + PITCH;
                        end else begin
                            addr_valid <= 1'b0;
                            done       <= 1'b1;
                            state      <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_rd_addr_gen.sv
// Bench for tile_rd_addr_gen: table-driven tiles with a scoreboard queue on a
// 2x2x2 configuration, plus reset, abort and 8-bit address wrap sequences.
module tb_tile_rd_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base;
    logic        clean;
    logic [15:0] addr;
    logic        addr_valid;
    logic        addr_ready;
    logic        busy;
    logic        done;

    logic        b_start;
    logic [7:0]  b_base;
    logic        b_clean;
    logic [7:0]  b_addr;
    logic        b_valid;
    logic        b_ready;
    logic        b_busy;
    logic        b_done;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    typedef struct packed {
        logic [15:0]       b;
        logic [1:0]        mode;
        logic [7:0]        restart_at;
        logic [7:0]        clean_at;
        logic [7:0][15:0]  exp;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    tile_rd_addr_gen #(.AW(16), .ROW(2), .COL(2), .CH(2), .FM_COL(4), .CW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .clean     (clean),
        .addr      (addr),
        .addr_valid(addr_valid),
        .addr_ready(addr_ready),
        .busy      (busy),
        .done      (done)
    );

    tile_rd_addr_gen #(.AW(8), .ROW(1), .COL(2), .CH(4), .FM_COL(2), .CW(8)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .start     (b_start),
        .base      (b_base),
        .clean     (b_clean),
        .addr      (b_addr),
        .addr_valid(b_valid),
        .addr_ready(b_ready),
        .busy      (b_busy),
        .done      (b_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_tile(input vec_t v);
        int          acc       = 0;
        int          busy_cnt  = 0;
        bit          stall     = 0;
        bit          exp_done  = 0;
        bit          fin       = 0;
        bit          restarted = 0;
        bit          cleaning  = 0;
        logic [15:0] prev      = '0;
        logic [15:0] e;
        for (int i = 0; i < 8; i++) exp_q.push_back(v.exp[i]);
        start      = 1'b1;
        base       = v.b;
        addr_ready = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            start = 1'b0;
            clean = 1'b0;
            if (busy) busy_cnt++;
            chk("done_timing", done, exp_done);
            if (exp_done || cleaning) begin
                chk("valid_off", addr_valid, 0);
                chk("busy_off", busy, 0);
                if (cleaning) exp_q.delete();
                fin = 1;
            end else begin
                if (stall) chk("stall_hold", addr, prev);
                chk("valid_on", addr_valid, 1);
                addr_ready = (v.mode == 2'd0) || (cyc % 3 == 0);
                if (v.restart_at == acc && !restarted) begin
                    start     = 1'b1;
                    base      = 16'h0500;
                    restarted = 1;
                end
                if (v.clean_at == acc) begin
                    clean    = 1'b1;
                    cleaning = 1;
                end else if (addr_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("queue_underrun", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("addr", addr, e);
                    end
                    acc++;
                    stall = 0;
                    if (acc == 8) exp_done = 1;
                end else begin
                    stall = 1;
                    prev  = addr;
                end
                @(negedge clk);
            end
        end
        if (!fin) chk("tile_timeout", 0, 1);
        chk("accepts", acc, (v.clean_at == 8'hFF) ? 8 : int'(v.clean_at));
        if (v.mode == 2'd0 && v.clean_at == 8'hFF) chk("busy_cycles", busy_cnt, 8);
        chk("queue_empty", exp_q.size(), 0);
        start      = 1'b0;
        clean      = 1'b0;
        addr_ready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        logic [7:0] wexp[8];
        wexp = '{8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1};

        vecs[0] = '{b: 16'd10, mode: 2'd0, restart_at: 8'hFF, clean_at: 8'hFF,
                    exp: {16'd21, 16'd20, 16'd19, 16'd18, 16'd13, 16'd12, 16'd11, 16'd10}};
        vecs[1] = '{b: 16'd10, mode: 2'd1, restart_at: 8'hFF, clean_at: 8'hFF,
                    exp: {16'd21, 16'd20, 16'd19, 16'd18, 16'd13, 16'd12, 16'd11, 16'd10}};
        vecs[2] = '{b: 16'd10, mode: 2'd0, restart_at: 8'd2, clean_at: 8'hFF,
                    exp: {16'd21, 16'd20, 16'd19, 16'd18, 16'd13, 16'd12, 16'd11, 16'd10}};
        vecs[3] = '{b: 16'd1911, mode: 2'd0, restart_at: 8'hFF, clean_at: 8'hFF,
                    exp: {16'd1922, 16'd1921, 16'd1920, 16'd1919, 16'd1914, 16'd1913, 16'd1912, 16'd1911}};
        vecs[4] = '{b: 16'd10, mode: 2'd0, restart_at: 8'hFF, clean_at: 8'd5,
                    exp: {16'd21, 16'd20, 16'd19, 16'd18, 16'd13, 16'd12, 16'd11, 16'd10}};
        vecs[5] = '{b: 16'd0, mode: 2'd1, restart_at: 8'hFF, clean_at: 8'hFF,
                    exp: {16'd11, 16'd10, 16'd9, 16'd8, 16'd3, 16'd2, 16'd1, 16'd0}};
        vecs[6] = '{b: 16'hFFFE, mode: 2'd0, restart_at: 8'hFF, clean_at: 8'hFF,
                    exp: {16'd9, 16'd8, 16'd7, 16'd6, 16'd1, 16'd0, 16'd65535, 16'd65534}};

        rst        = 1'b1;
        start      = 1'b0;
        base       = '0;
        clean      = 1'b0;
        addr_ready = 1'b0;
        b_start    = 1'b0;
        b_base     = '0;
        b_clean    = 1'b0;
        b_ready    = 1'b0;
        #1;
        chk("rst_addr", addr, 0);
        chk("rst_valid", addr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 7; t++) run_tile(vecs[t]);

        // Asynchronous reset landing between clock edges in the middle of a tile.
        start      = 1'b1;
        base       = 16'd40;
        addr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_addr", addr, 0);
        chk("arst_valid", addr_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle_busy", busy, 0);
            chk("post_rst_idle_valid", addr_valid, 0);
        end
        run_tile(vecs[5]);

        // 8-bit address space: the tile crosses the top of memory.
        b_start = 1'b1;
        b_base  = 8'd250;
        b_ready = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("wrap_valid", b_valid, 1);
            chk("wrap_addr", b_addr, wexp[i]);
            @(negedge clk);
        end
        chk("wrap_done", b_done, 1);
        chk("wrap_valid_off", b_valid, 0);
        chk("wrap_busy_off", b_busy, 0);
        @(negedge clk);
        chk("wrap_done_end", b_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
